// File: rtl/l2_masked_array.sv
// ---------------------------------------------------------------------------
// l2_masked_array
//   DEPTH x WIDTH line store for one L2 way (data or tag). Writes are
//   masked at 16-bit word granularity, reads are registered (1-cycle latency).
//   After reset a hardware sweep zeroes every line; requests are dropped
//   while the sweep runs.
//
// Ports
//   clk        clock
//   reset      synchronous, active-high reset (restarts the sweep)
//   init_busy  high while the zeroing sweep runs
//   write      write request
//   wmask      NWORD bits, bit i enables datain[16i+15:16i]
//   windex     write line index
//   datain     write data
//   read       read request
//   rindex     read line index
//   dataout    registered read data (holds when no read)
//   dout_valid high the cycle after an accepted read
//
// Build option
//   L2_ARRAY_BYPASS_EN : same-cycle read/write to one index returns the
//                        merged (new) line instead of the old contents.
// ---------------------------------------------------------------------------
module l2_masked_array #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH),
  parameter int NWORD = WIDTH / 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic             init_busy,
  input  logic             write,
  input  logic [NWORD-1:0] wmask,
  input  logic [IDX_W-1:0] windex,
  input  logic [WIDTH-1:0] datain,
  input  logic             read,
  input  logic [IDX_W-1:0] rindex,
  output logic [WIDTH-1:0] dataout,
  output logic             dout_valid
);

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_e;

  localparam logic [IDX_W:0]   DEPTH_C  = (IDX_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               init_busy_q, init_busy_d;
  logic [WIDTH-1:0]   dataout_q, dataout_d;
  logic               dout_valid_q, dout_valid_d;
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [WIDTH-1:0]   mem_d [DEPTH];

  logic               w_in_range, r_in_range;
  logic               wr_ok, rd_ok;
  logic [WIDTH-1:0]   wmask_bits;
  logic [WIDTH-1:0]   wr_line, rd_line, wr_merged, rd_result;

  // Request qualification and per-word merge of the addressed line.
  always_comb begin
    w_in_range = ({1'b0, windex} < DEPTH_C);
    r_in_range = ({1'b0, rindex} < DEPTH_C);
    wr_ok      = (state_q == ST_READY) && write && w_in_range;
    rd_ok      = (state_q == ST_READY) && read;

    wmask_bits = '0;
    for (int unsigned w = 0; w < NWORD; w++) begin
      wmask_bits[16*w +: 16] = {16{wmask[w]}};
    end

    wr_line   = w_in_range ? mem_q[windex] : '0;
    rd_line   = r_in_range ? mem_q[rindex] : '0;
    wr_merged = (datain & wmask_bits) | (wr_line & ~wmask_bits);

`ifdef L2_ARRAY_BYPASS_EN
    // wr_ok implies windex is in range, so wr_line is the line being read.
    rd_result = (wr_ok && (windex == rindex)) ? wr_merged : rd_line;
`else
    rd_result = rd_line;
`endif
  end

  // Array next state: sweep zeroing during INIT, masked writes in READY.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (!reset) begin
      if (state_q == ST_INIT) begin
        mem_d[ptr_q] = '0;
      end else if (wr_ok) begin
        mem_d[windex] = wr_merged;
      end
    end
  end

  // Control and registered outputs.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    init_busy_d  = init_busy_q;
    dataout_d    = dataout_q;
    dout_valid_d = 1'b0;
    case (state_q)
      ST_INIT: begin
        ptr_d = ptr_q + IDX_W'(1);
        // busy clears together with the last line write, giving exactly
        // DEPTH busy cycles after reset is released.
        if (ptr_q == LAST_IDX) begin
          state_d     = ST_READY;
          ptr_d       = '0;
          init_busy_d = 1'b0;
        end
      end
      ST_READY: begin
        init_busy_d = 1'b0;
        if (rd_ok) begin
          dataout_d    = rd_result;
          dout_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_INIT;
        ptr_d       = '0;
        init_busy_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_INIT;
      ptr_q        <= '0;
      init_busy_q  <= 1'b1;
      dataout_q    <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      init_busy_q  <= init_busy_d;
      dataout_q    <= dataout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // Storage is not reset; the sweep clears it.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  assign init_busy  = init_busy_q;
  assign dataout    = dataout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_l2_masked_array.sv
module tb_l2_masked_array;

`ifdef L2_ARRAY_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b0;

  // DEPTH=8, WIDTH=256 instance
  logic         w8 = 0, r8 = 0;
  logic [15:0]  wm8 = '0;
  logic [2:0]   wi8 = '0, ri8 = '0;
  logic [255:0] d8 = '0, q8;
  logic         v8, b8;

  // DEPTH=6, WIDTH=32 instance (out-of-range indices 6,7)
  logic         w6 = 0, r6 = 0;
  logic [1:0]   wm6 = '0;
  logic [2:0]   wi6 = '0, ri6 = '0;
  logic [31:0]  d6 = '0, q6;
  logic         v6, b6;

  l2_masked_array dut8 (
    .clk(clk), .reset(reset), .init_busy(b8),
    .write(w8), .wmask(wm8), .windex(wi8), .datain(d8),
    .read(r8), .rindex(ri8), .dataout(q8), .dout_valid(v8)
  );

  l2_masked_array #(.WIDTH(32), .DEPTH(6)) dut6 (
    .clk(clk), .reset(reset), .init_busy(b6),
    .write(w6), .wmask(wm6), .windex(wi6), .datain(d6),
    .read(r6), .rindex(ri6), .dataout(q6), .dout_valid(v6)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain line arrays plus a countdown of sweep cycles.
  logic [255:0] mm8 [8];
  logic [31:0]  mm6 [6];
  int           left8 = 0, left6 = 0;
  logic [255:0] e_q8 = '0;
  logic [31:0]  e_q6 = '0;
  logic         e_v8 = 0, e_b8 = 0, e_v6 = 0, e_b6 = 0;

  task automatic model_edge();
    logic [255:0] o8;
    logic [31:0]  o6;
    if (reset) begin
      left8 = 8; left6 = 6;
      e_b8 = 1; e_b6 = 1; e_v8 = 0; e_v6 = 0;
      e_q8 = '0; e_q6 = '0;
    end else begin
      if (left8 > 0) begin
        mm8[8-left8] = '0;
        left8--;
        e_b8 = (left8 > 0);
        e_v8 = 0;
      end else begin
        e_v8 = r8;
        if (r8) begin
          o8 = mm8[ri8];
          for (int i = 0; i < 16; i++)
            if (BYP && w8 && wi8 == ri8 && wm8[i]) o8[16*i +: 16] = d8[16*i +: 16];
          e_q8 = o8;
        end
        if (w8)
          for (int i = 0; i < 16; i++)
            if (wm8[i]) mm8[wi8][16*i +: 16] = d8[16*i +: 16];
      end
      if (left6 > 0) begin
        mm6[6-left6] = '0;
        left6--;
        e_b6 = (left6 > 0);
        e_v6 = 0;
      end else begin
        e_v6 = r6;
        if (r6) begin
          o6 = (ri6 < 3'd6) ? mm6[ri6] : '0;
          for (int i = 0; i < 2; i++)
            if (BYP && w6 && wi6 == ri6 && wi6 < 3'd6 && wm6[i]) o6[16*i +: 16] = d6[16*i +: 16];
          e_q6 = o6;
        end
        if (w6 && wi6 < 3'd6)
          for (int i = 0; i < 2; i++)
            if (wm6[i]) mm6[wi6][16*i +: 16] = d6[16*i +: 16];
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".busy8"}, 256'(b8), 256'(e_b8));
    chk({tag, ".valid8"}, 256'(v8), 256'(e_v8));
    chk({tag, ".dout8"}, q8, e_q8);
    chk({tag, ".busy6"}, 256'(b6), 256'(e_b6));
    chk({tag, ".valid6"}, 256'(v6), 256'(e_v6));
    chk({tag, ".dout6"}, 256'(q6), 256'(e_q6));
  endtask

  task automatic idle_all();
    w8 = 0; r8 = 0; wm8 = '0; w6 = 0; r6 = 0; wm6 = '0;
  endtask

  // Counts busy cycles of both instances, starting right after a reset edge.
  task automatic count_busy(input string tag);
    int n8, n6;
    n8 = 0; n6 = 0;
    for (int k = 0; k < 20; k++) begin
      if (b8) n8++;
      if (b6) n6++;
      if (!b8 && !b6) break;
      tick();
    end
    chk({tag, ".busy_cycles8"}, 256'(n8), 256'(8));
    chk({tag, ".busy_cycles6"}, 256'(n6), 256'(6));
  endtask

  typedef struct {
    logic       w;
    logic [15:0] wm;
    logic [2:0] wi;
    logic [15:0] dw;
    logic       r;
    logic [2:0] ri;
    logic       ev;
    logic [15:0] ehi;
    logic [15:0] elo;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [15:0] byp_w;
    logic [255:0] exp_line;
    byp_w = BYP ? 16'hFFFF : 16'h0000;
    tbl[0] = '{1'b1, 16'h00FF, 3'd3, 16'hA5A5, 1'b0, 3'd0, 1'b0, 16'h0000, 16'h0000};
    tbl[1] = '{1'b1, 16'hFF00, 3'd3, 16'h1234, 1'b0, 3'd0, 1'b0, 16'h0000, 16'h0000};
    tbl[2] = '{1'b0, 16'h0000, 3'd0, 16'h0000, 1'b1, 3'd3, 1'b1, 16'h1234, 16'hA5A5};
    tbl[3] = '{1'b1, 16'hFFFF, 3'd5, 16'hFFFF, 1'b1, 3'd5, 1'b1, byp_w,    byp_w};
    tbl[4] = '{1'b0, 16'h0000, 3'd0, 16'h0000, 1'b1, 3'd5, 1'b1, 16'hFFFF, 16'hFFFF};
    tbl[5] = '{1'b1, 16'h0000, 3'd1, 16'hFFFF, 1'b0, 3'd0, 1'b0, 16'hFFFF, 16'hFFFF};
    tbl[6] = '{1'b0, 16'h0000, 3'd0, 16'h0000, 1'b1, 3'd1, 1'b1, 16'h0000, 16'h0000};
    tbl[7] = '{1'b0, 16'h0000, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 16'h0000, 16'h0000};
    tbl[8] = tbl[7];
    tbl[9] = tbl[7];

    // Reset state and sweep length
    reset = 1; tick();
    chk("reset.busy8", 256'(b8), 256'(1));
    chk("reset.valid8", 256'(v8), 256'(0));
    chk("reset.dout8", q8, '0);
    chk("reset.busy6", 256'(b6), 256'(1));
    reset = 0;
    count_busy("sweep");

    // Every line reads back zero after the sweep
    for (int i = 0; i < 8; i++) begin
      r8 = 1; ri8 = 3'(i);
      tick();
      chk($sformatf("zero.idx%0d.dout", i), q8, '0);
      chk($sformatf("zero.idx%0d.valid", i), 256'(v8), 256'(1));
    end
    idle_all();

    // Table: masked writes, same-index read/write, mask=0, held read data
    for (int i = 0; i < 10; i++) begin
      w8 = tbl[i].w; wm8 = tbl[i].wm; wi8 = tbl[i].wi; d8 = {16{tbl[i].dw}};
      r8 = tbl[i].r; ri8 = tbl[i].ri;
      tick();
      exp_line = {{8{tbl[i].ehi}}, {8{tbl[i].elo}}};
      chk($sformatf("vec%0d.valid", i), 256'(v8), 256'(tbl[i].ev));
      chk($sformatf("vec%0d.dout", i), q8, exp_line);
      cmp_model($sformatf("vec%0d", i));
    end
    idle_all();

    // Out-of-range indices on the DEPTH=6 instance
    w6 = 1; wm6 = 2'b11; wi6 = 3'd2; d6 = 32'hDEADBEEF; tick();
    wi6 = 3'd7; d6 = '1; tick();
    wi6 = 3'd6; tick();
    w6 = 0; r6 = 1; ri6 = 3'd2; tick();
    chk("oor.idx2", 256'(q6), 256'(32'hDEADBEEF));
    ri6 = 3'd7; tick();
    chk("oor.idx7.dout", 256'(q6), '0);
    chk("oor.idx7.valid", 256'(v6), 256'(1));
    for (int i = 0; i < 6; i++) begin
      ri6 = 3'(i); tick();
      chk($sformatf("oor.line%0d", i), 256'(q6), 256'((i == 2) ? 32'hDEADBEEF : 32'h0));
    end
    idle_all();

    // Requests during the sweep are dropped
    reset = 1; tick(); reset = 0;
    tick();
    w8 = 1; wm8 = '1; wi8 = 3'd0; d8 = '1; r8 = 1; ri8 = 3'd0;
    w6 = 1; wm6 = '1; wi6 = 3'd0; d6 = '1; r6 = 1; ri6 = 3'd0;
    tick();
    chk("init_req.valid8", 256'(v8), 256'(0));
    chk("init_req.valid6", 256'(v6), 256'(0));
    chk("init_req.busy8", 256'(b8), 256'(1));
    idle_all();
    for (int k = 0; k < 20 && b8; k++) tick();
    chk("init_req.done", 256'(b8), 256'(0));
    r8 = 1; ri8 = 3'd0; r6 = 1; ri6 = 3'd0; tick();
    chk("init_req.line0_8", q8, '0);
    chk("init_req.line0_6", 256'(q6), '0);
    idle_all();

    // Reset reasserted mid-sweep restarts the full sweep
    reset = 1; tick(); reset = 0;
    for (int k = 0; k < 4; k++) tick();
    reset = 1; tick(); reset = 0;
    count_busy("restart");
    cmp_model("restart");

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      w8 = 1'($urandom); r8 = 1'($urandom);
      case ($urandom_range(0, 3))
        0: wm8 = '0;
        1: wm8 = '1;
        default: wm8 = 16'($urandom);
      endcase
      for (int j = 0; j < 8; j++) d8[32*j +: 32] = $urandom;
      wi8 = 3'($urandom);
      ri8 = ($urandom_range(0, 2) == 0) ? wi8 : 3'($urandom);
      w6 = 1'($urandom); r6 = 1'($urandom); wm6 = 2'($urandom);
      d6 = $urandom;
      wi6 = 3'($urandom);
      ri6 = ($urandom_range(0, 2) == 0) ? wi6 : 3'($urandom);
      tick();
      cmp_model($sformatf("rnd%0d", n));
    end
    reset = 0;
    idle_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
